// File: rtl/conv_encoder_stream_if.sv
// rtl/conv_encoder_stream_if.sv - bit-in / symbol-out handshake bundle for conv_encoder_stream
interface conv_encoder_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/conv_encoder_stream.sv
// rtl/conv_encoder_stream.sv - rate-1/2 K=3 streaming convolutional encoder; CONV_ENC_TAIL_EN adds zero-tail frame termination
module conv_encoder_stream #(
  parameter int         FRAME_LEN = 8,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_encoder_stream_if.slave bus,
  output logic [1:0]           enc_state,
  output logic                 busy
);
  localparam int            CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [CW-1:0] bit_cnt;
  logic [1:0]    sreg;
  logic          out_valid_q;
  logic          out_last_q;
  logic [1:0]    out_sym_q;
  logic          slot_free;
  logic          accept;
  logic          load;
  logic          u;
  logic          last_bit;
  logic          sym_last;

  function automatic logic [1:0] encode(input logic uu, input logic [1:0] st);
    logic [2:0] taps;
    taps = {uu, st};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  assign slot_free     = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_bit      = (bit_cnt == LAST_IDX);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign bus.out_last  = out_last_q;
  assign enc_state     = sreg;

`ifdef CONV_ENC_TAIL_EN
  localparam logic [0:0] ST_DATA = 1'b0;
  localparam logic [0:0] ST_TAIL = 1'b1;

  logic [0:0] fsm;
  logic       tail_cnt;
  logic       in_tail;

  assign in_tail      = (fsm == ST_TAIL);
  // rst_n gates in_ready so the source never sees a handshake while reset is held
  assign bus.in_ready = rst_n && !in_tail && slot_free;
  assign load         = accept || (in_tail && slot_free);
  assign u            = in_tail ? 1'b0 : bus.in_bit;
  assign sym_last     = in_tail && tail_cnt;
  assign busy         = (bit_cnt != '0) || in_tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= ST_DATA;
      tail_cnt <= 1'b0;
    end else if (accept && last_bit) begin
      fsm      <= ST_TAIL;
      tail_cnt <= 1'b0;
    end else if (in_tail && slot_free) begin
      tail_cnt <= !tail_cnt;
      if (tail_cnt) begin
        fsm <= ST_DATA;
      end
    end
  end
`else
  assign bus.in_ready = rst_n && slot_free;
  assign load         = accept;
  assign u            = bus.in_bit;
  assign sym_last     = last_bit;
  assign busy         = (bit_cnt != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
    end
  end

  // Encoder state only advances when a symbol enters the slot, so it freezes under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg        <= 2'b00;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_last_q  <= 1'b0;
    end else if (load) begin
      sreg        <= {u, sreg[1]};
      out_valid_q <= 1'b1;
      out_sym_q   <= encode(u, sreg);
      out_last_q  <= sym_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end
endmodule
